// File: rtl/if_id_fetch_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction SRAM port and IF/ID outputs.
// master = the fetch stage; slave = its surroundings (hazard unit, SRAM, ID stage).
interface if_id_fetch_if;
  logic        IF_PCWr;
  logic        IF_IDWr;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        ExceptionValid;
  logic [31:0] ExceptionVector;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic [31:0] IF_PC;
  logic [31:0] ID_PC;
  logic [31:0] ID_Instr;
  logic        ID_Valid;
  logic        ID_AdEL;

  modport master (
    input  IF_PCWr, IF_IDWr, BranchTaken, BranchTarget,
    input  ExceptionValid, ExceptionVector, inst_sram_rdata,
    output inst_sram_en, inst_sram_addr,
    output IF_PC, ID_PC, ID_Instr, ID_Valid, ID_AdEL
  );

  modport slave (
    output IF_PCWr, IF_IDWr, BranchTaken, BranchTarget,
    output ExceptionValid, ExceptionVector, inst_sram_rdata,
    input  inst_sram_en, inst_sram_addr,
    input  IF_PC, ID_PC, ID_Instr, ID_Valid, ID_AdEL
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Fetch stage and IF/ID register: owns the PC, issues 1-cycle-latency SRAM reads,
// and holds the returned instruction across hazard stalls.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  if_id_fetch_if.master bus
);

  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q, id_adel_d;
  logic        held_q, held_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  logic advance;
  logic misal;

  // A write-enable mismatch from the hazard unit is treated as a stall.
  assign advance = bus.IF_PCWr & bus.IF_IDWr;
  assign misal   = (if_pc_q[1:0] != 2'b00);

  assign bus.inst_sram_en   = !rst & advance & !bus.ExceptionValid & !misal;
  assign bus.inst_sram_addr = if_pc_q;

  always_comb begin
    if_pc_d      = if_pc_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;
    id_adel_d    = id_adel_q;
    held_d       = held_q;
    hold_instr_d = hold_instr_q;
    if (bus.ExceptionValid) begin
      if_pc_d    = bus.ExceptionVector;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
      held_d     = 1'b0;
    end else if (!advance) begin
      // Capture only on the first stall cycle; later SRAM data is stale.
      if (!held_q) begin
        hold_instr_d = bus.inst_sram_rdata;
        held_d       = 1'b1;
      end
    end else begin
      if_pc_d    = bus.BranchTaken ? bus.BranchTarget : if_pc_q + 32'd4;
      id_pc_d    = if_pc_q;
      id_valid_d = 1'b1;
      id_adel_d  = misal;
      held_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc_q      <= RESET_PC;
      id_pc_q      <= 32'd0;
      id_valid_q   <= 1'b0;
      id_adel_q    <= 1'b0;
      held_q       <= 1'b0;
      hold_instr_q <= 32'd0;
    end else begin
      if_pc_q      <= if_pc_d;
      id_pc_q      <= id_pc_d;
      id_valid_q   <= id_valid_d;
      id_adel_q    <= id_adel_d;
      held_q       <= held_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_comb begin
    if (!id_valid_q || id_adel_q) begin
      bus.ID_Instr = NOP_INSTR;
    end else if (held_q) begin
      bus.ID_Instr = hold_instr_q;
    end else begin
      bus.ID_Instr = bus.inst_sram_rdata;
    end
  end

  assign bus.IF_PC    = if_pc_q;
  assign bus.ID_PC    = id_pc_q;
  assign bus.ID_Valid = id_valid_q;
  assign bus.ID_AdEL  = id_adel_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: inputs change on negedge, outputs sampled
// 1 time unit later (combinational) or 1 time unit after posedge (registered).
module tb_if_id_fetch_stage;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  if_id_fetch_if bus();

  if_id_fetch_stage #(
    .RESET_PC (32'hBFC0_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.IF_PCWr = 1'b1;
    bus.IF_IDWr = 1'b1;
    bus.BranchTaken = 1'b0;
    bus.BranchTarget = 32'h0;
    bus.ExceptionValid = 1'b0;
    bus.ExceptionVector = 32'h0;
    bus.inst_sram_rdata = 32'h1111_1111;

    // Reset state
    adv_cycle();
    adv_cycle();
    chk("rst_if_pc", bus.IF_PC, 32'hBFC0_0000);
    chk("rst_id_pc", bus.ID_PC, 32'h0);
    chk("rst_id_valid", {31'd0, bus.ID_Valid}, 32'd0);
    chk("rst_id_adel", {31'd0, bus.ID_AdEL}, 32'd0);
    chk("rst_en", {31'd0, bus.inst_sram_en}, 32'd0);
    chk("rst_id_instr", bus.ID_Instr, 32'h0);

    // Reset release
    at_neg();
    rst = 1'b0;
    #1;
    chk("rel_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("rel_addr", bus.inst_sram_addr, 32'hBFC0_0000);
    adv_cycle();
    chk("rel_id_pc", bus.ID_PC, 32'hBFC0_0000);
    chk("rel_id_valid", {31'd0, bus.ID_Valid}, 32'd1);
    chk("rel_if_pc", bus.IF_PC, 32'hBFC0_0004);
    at_neg();
    bus.inst_sram_rdata = 32'h3C1D_0000;
    #1;
    chk("rel_id_instr", bus.ID_Instr, 32'h3C1D_0000);

    // Advance twice: ID_PC=BFC00008, IF_PC=BFC0000C
    adv_cycle();
    adv_cycle();
    chk("pre_stall_id_pc", bus.ID_PC, 32'hBFC0_0008);
    chk("pre_stall_if_pc", bus.IF_PC, 32'hBFC0_000C);

    // Load-use stall, 2 cycles
    at_neg();
    bus.IF_PCWr = 1'b0;
    bus.IF_IDWr = 1'b0;
    bus.inst_sram_rdata = 32'h2402_0005;
    #1;
    chk("stall1_en", {31'd0, bus.inst_sram_en}, 32'd0);
    chk("stall1_instr", bus.ID_Instr, 32'h2402_0005);
    adv_cycle();
    at_neg();
    bus.inst_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("stall2_instr", bus.ID_Instr, 32'h2402_0005);
    chk("stall2_if_pc", bus.IF_PC, 32'hBFC0_000C);
    chk("stall2_id_pc", bus.ID_PC, 32'hBFC0_0008);
    chk("stall2_en", {31'd0, bus.inst_sram_en}, 32'd0);
    adv_cycle();
    chk("stall_end_instr", bus.ID_Instr, 32'h2402_0005);
    at_neg();
    bus.IF_PCWr = 1'b1;
    bus.IF_IDWr = 1'b1;
    #1;
    chk("unstall_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("unstall_addr", bus.inst_sram_addr, 32'hBFC0_000C);
    adv_cycle();
    chk("unstall_id_pc", bus.ID_PC, 32'hBFC0_000C);
    chk("unstall_if_pc", bus.IF_PC, 32'hBFC0_0010);
    at_neg();
    bus.inst_sram_rdata = 32'h8C43_0000;
    #1;
    chk("unstall_instr", bus.ID_Instr, 32'h8C43_0000);

    // Branch with delay slot
    adv_cycle();
    chk("br_pre_if_pc", bus.IF_PC, 32'hBFC0_0014);
    at_neg();
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 32'hBFC0_0100;
    adv_cycle();
    chk("br_id_pc", bus.ID_PC, 32'hBFC0_0014);
    chk("br_id_valid", {31'd0, bus.ID_Valid}, 32'd1);
    chk("br_if_pc", bus.IF_PC, 32'hBFC0_0100);

    // Branch during stall (mismatched write enables count as a stall)
    at_neg();
    bus.IF_PCWr = 1'b1;
    bus.IF_IDWr = 1'b0;
    bus.BranchTarget = 32'hBFC0_0200;
    #1;
    chk("brst_en", {31'd0, bus.inst_sram_en}, 32'd0);
    adv_cycle();
    chk("brst_if_pc", bus.IF_PC, 32'hBFC0_0100);
    chk("brst_id_pc", bus.ID_PC, 32'hBFC0_0014);
    at_neg();
    bus.IF_IDWr = 1'b1;
    adv_cycle();
    chk("brre_if_pc", bus.IF_PC, 32'hBFC0_0200);
    chk("brre_id_pc", bus.ID_PC, 32'hBFC0_0100);

    // Exception over stall
    at_neg();
    bus.BranchTaken = 1'b0;
    bus.IF_PCWr = 1'b0;
    bus.IF_IDWr = 1'b0;
    bus.ExceptionValid = 1'b1;
    bus.ExceptionVector = 32'hBFC0_0380;
    bus.inst_sram_rdata = 32'hABCD_1234;
    #1;
    chk("exc_en", {31'd0, bus.inst_sram_en}, 32'd0);
    adv_cycle();
    chk("exc_if_pc", bus.IF_PC, 32'hBFC0_0380);
    chk("exc_id_valid", {31'd0, bus.ID_Valid}, 32'd0);
    chk("exc_id_instr", bus.ID_Instr, 32'h0);
    at_neg();
    bus.ExceptionValid = 1'b0;
    bus.IF_PCWr = 1'b1;
    bus.IF_IDWr = 1'b1;
    adv_cycle();
    chk("post_exc_id_pc", bus.ID_PC, 32'hBFC0_0380);
    chk("post_exc_if_pc", bus.IF_PC, 32'hBFC0_0384);
    chk("post_exc_instr", bus.ID_Instr, 32'hABCD_1234);

    // Misaligned branch target
    at_neg();
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 32'hBFC0_0102;
    adv_cycle();
    chk("mis_if_pc", bus.IF_PC, 32'hBFC0_0102);
    at_neg();
    bus.BranchTaken = 1'b0;
    #1;
    chk("mis_en", {31'd0, bus.inst_sram_en}, 32'd0);
    adv_cycle();
    chk("mis_id_adel", {31'd0, bus.ID_AdEL}, 32'd1);
    chk("mis_id_pc", bus.ID_PC, 32'hBFC0_0102);
    chk("mis_id_valid", {31'd0, bus.ID_Valid}, 32'd1);
    chk("mis_id_instr", bus.ID_Instr, 32'h0);
    chk("mis_if_pc_next", bus.IF_PC, 32'hBFC0_0106);

    // PC wrap at top of address space
    at_neg();
    bus.ExceptionValid = 1'b1;
    bus.ExceptionVector = 32'hFFFF_FFFC;
    adv_cycle();
    at_neg();
    bus.ExceptionValid = 1'b0;
    adv_cycle();
    chk("wrap_if_pc", bus.IF_PC, 32'h0000_0000);
    chk("wrap_id_pc", bus.ID_PC, 32'hFFFF_FFFC);

    // Reset mid-stall
    at_neg();
    bus.IF_PCWr = 1'b0;
    bus.IF_IDWr = 1'b0;
    bus.inst_sram_rdata = 32'h5555_AAAA;
    adv_cycle();
    at_neg();
    rst = 1'b1;
    adv_cycle();
    chk("rstst_if_pc", bus.IF_PC, 32'hBFC0_0000);
    chk("rstst_id_valid", {31'd0, bus.ID_Valid}, 32'd0);
    at_neg();
    rst = 1'b0;
    bus.IF_PCWr = 1'b1;
    bus.IF_IDWr = 1'b1;
    bus.inst_sram_rdata = 32'h1234_5678;
    #1;
    chk("rstst_en", {31'd0, bus.inst_sram_en}, 32'd1);
    adv_cycle();
    chk("rstst_id_pc", bus.ID_PC, 32'hBFC0_0000);
    chk("rstst_id_valid2", {31'd0, bus.ID_Valid}, 32'd1);
    chk("rstst_instr", bus.ID_Instr, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core. Sits directly downstream of the load-use hazard unit and consumes its IF_PCWr/IF_IDWr.
- Owns the PC and issues requests to the synchronous instruction SRAM (1-cycle read latency).
- Holds the returned instruction across stalls and presents PC/instruction/valid to ID.
- Handles branch redirect (delay slot preserved), exception redirect/flush, and fetch-address-error tagging.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction presented to ID when ID_Valid=0.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
IF_PCWr  in  1  PC write enable from hazard unit; 0 = stall.
IF_IDWr  in  1  IF/ID write enable from hazard unit; 0 = stall.
BranchTaken  in  1  branch/jump in ID resolved taken.
BranchTarget  in  32  redirect target for BranchTaken.
ExceptionValid  in  1  exception/eret commit; flush IF and ID.
ExceptionVector  in  32  redirect target for ExceptionValid.
inst_sram_en  out  1  fetch request strobe.
inst_sram_addr  out  32  fetch address, equals IF_PC.
inst_sram_rdata  in  32  read data, valid the cycle after an enabled request.
IF_PC  out  32  current fetch PC.
ID_PC  out  32  PC of instruction in ID.
ID_Instr  out  32  instruction in ID.
ID_Valid  out  1  ID holds a live instruction.
ID_AdEL  out  1  ID instruction had a misaligned fetch address.

Behaviour:
- Definitions:
  - advance = IF_PCWr & IF_IDWr. The hazard unit drives both equal; any mismatch is treated as a stall.
  - misal = (IF_PC[1:0] != 2'b00).
- Reset (rst=1 at posedge):
  - IF_PC=RESET_PC; ID_PC=0; ID_Valid=0; ID_AdEL=0.
  - Internal held flag=0; hold register=0.
  - inst_sram_en=0 while rst=1.
- Request (combinational):
  - inst_sram_en = !rst & advance & !ExceptionValid & !misal.
  - inst_sram_addr = IF_PC.
  - At most one request is outstanding; its data is consumed in the following cycle.
- IF_PC next-state, priority high to low:
  1. rst → RESET_PC.
  2. ExceptionValid → ExceptionVector.
  3. !advance → hold.
  4. BranchTaken → BranchTarget.
  5. Otherwise IF_PC+4, 32-bit wrap, no carry out.
- BranchTaken while stalled is ignored. The branch stays in ID and is re-presented after the stall.
- IF/ID register next-state, priority high to low:
  1. rst → reset values.
  2. ExceptionValid → ID_Valid=0, ID_AdEL=0, held=0. ID_PC is don't-care (keep).
  3. !advance → ID_PC/ID_Valid/ID_AdEL hold. If held=0: hold register←inst_sram_rdata and held←1. If held=1: no change.
  4. advance → ID_PC←IF_PC; ID_Valid←1; ID_AdEL←misal; held←0.
- Branch delay slot: the instruction in IF when BranchTaken=1 advances into ID normally and is not flushed.
- ID_Instr (combinational), first match wins:
  - !ID_Valid or ID_AdEL → NOP_INSTR.
  - held → hold register.
  - otherwise → inst_sram_rdata.
- Stall duration: a stall of N cycles leaves ID_Instr stable for all N cycles, because the capture happens only on the first stall cycle.
- Exception and stall in the same cycle: the exception wins, so the redirect and flush occur regardless of IF_PCWr/IF_IDWr.
- Reset mid-stall: all held state is cleared. The next fetch after rst deasserts is RESET_PC, with ID_Valid=1 one cycle later.
- Misaligned IF_PC: no SRAM request is issued. The instruction enters ID as NOP_INSTR with ID_Valid=1 and ID_AdEL=1, so downstream raises AdEL with ID_PC as BadVAddr.

Test Plan:
- Reset release:
  - Stimulus: rst 1→0 with advance=1.
  - Required response: cycle0 inst_sram_addr=BFC00000, en=1; next cycle ID_PC=BFC00000, ID_Valid=1, ID_Instr=rdata; IF_PC=BFC00004.
- Load-use stall:
  - Stimulus: IF_PCWr=IF_IDWr=0 for 2 cycles with ID_PC=BFC00008; rdata=24020005 in first stall cycle, then garbage.
  - Required response: ID_Instr stays 24020005 for both cycles; en=0; IF_PC holds BFC0000C; after release ID_PC=BFC0000C.
- Branch with delay slot:
  - Stimulus: BranchTaken=1, BranchTarget=BFC00100, IF_PC=BFC00014.
  - Required response: ID_PC=BFC00014 with ID_Valid=1 next cycle; IF_PC=BFC00100.
- Branch during stall:
  - Stimulus: BranchTaken=1 with advance=0.
  - Required response: IF_PC unchanged. Re-asserting BranchTaken with advance=1 redirects.
- Exception over stall:
  - Stimulus: ExceptionValid=1, ExceptionVector=BFC00380, advance=0.
  - Required response: next cycle IF_PC=BFC00380, ID_Valid=0, ID_Instr=0, en=0 during the exception cycle.
- Misaligned target:
  - Stimulus: BranchTarget=BFC00102.
  - Required response: next cycle en=0; following cycle ID_AdEL=1, ID_PC=BFC00102, ID_Instr=00000000, ID_Valid=1.
